ccff_bitstream_loader: RTL
==========================

# ccff_bitstream_loader

Byte-to-serial configuration loader that drives the head of a configuration-chain (ccff) shift path, such as the chain threaded through the CLB logic elements via `ccff_head`/`ccff_tail`. It accepts configuration bytes over a valid/ready handshake and serialises exactly `CHAIN_LEN` bits MSB-first onto `ccff_head`. It produces a shift-enable that the tile top uses to gate the chain's `prog_clk`. An optional readback pass recirculates the chain through `ccff_tail` and checks a CRC.

## Interface
Parameters:
- `CHAIN_LEN`, default 72: total configuration bits in the downstream chain; must be ≥ 1.
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of the bit counter.

Ports:
- `prog_clk`  in  1  — the block's only clock; all state is updated on its rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — single-cycle request to begin a load; ignored while `busy`=1.
- `data_in`  in  8  — configuration byte.
- `data_valid`  in  1  — `data_in` is valid.
- `data_ready`  out  1  — loader can accept a byte this cycle.
- `ccff_head`  out  1  — serial bit to the chain head (registered).
- `ccff_shift_en`  out  1  — the chain advances on this `prog_clk` edge (registered, aligned with `ccff_head`).
- `ccff_tail`  in  1  — chain tail; used only when `CCFF_READBACK_EN` is defined.
- `busy`  out  1  — a load or verify is in progress.
- `done`  out  1  — one-cycle pulse when the operation completes.
- `err`  out  1  — sticky readback-mismatch flag; cleared by the next `start`.

## Operation
- States: `IDLE`, `FETCH`, `SHIFT`, `VERIFY` (macro only), `FIN`.
- `IDLE`: `start` → `FETCH`. Entering `FETCH` from `IDLE` clears the bit counter, the CRC, and `err`; `busy` goes high.
- `FETCH`: `data_ready`=1.
  - On `data_valid & data_ready`, latch the byte into an 8-bit shift register and go to `SHIFT`.
  - If `data_valid` is low, wait indefinitely; `ccff_shift_en`=0 while waiting.
- `SHIFT`: each cycle drive `ccff_head`=sreg[7] with `ccff_shift_en`=1, shift sreg left, and increment the bit counter.
  - Leave `SHIFT` after 8 bits, or earlier when the counter reaches `CHAIN_LEN`.
  - Exit to `FETCH` if bits remain, otherwise to `VERIFY` (macro) or `FIN`.
  - Low-order bits of the final byte beyond `CHAIN_LEN` are discarded.
- CRC-8, polynomial 0x07, init 0x00, updated per shifted bit:
  - fb = crc[7] ^ bit
  - crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 0)
- `FIN`: `done`=1 for one cycle, `busy`=0, then → `IDLE`.
- `data_valid` while `data_ready`=0 is ignored; the byte is not consumed.
- `start` while `busy`=1 is ignored.
- Reset (asynchronous, any state): → `IDLE`. All outputs go to 0: `data_ready`, `ccff_head`, `ccff_shift_en`, `busy`, `done`, `err`. Chain contents are undefined afterwards and a new `start` is required.

## Timing
- Byte accept → first `ccff_shift_en` in the following cycle.
- Per byte: 1 fetch cycle plus 8 shift cycles, giving 9 cycles/byte with `data_valid` held high.
- Full load: `ceil(CHAIN_LEN/8)` fetch cycles + `CHAIN_LEN` shift cycles.
- `done` asserts in the cycle after the last shift (or after the last verify cycle when the macro is defined).
- `ccff_shift_en` is never high during `IDLE`, `FETCH` or `FIN`.

## Configuration
- Macro `CCFF_READBACK_EN`.
- Defined:
  - After the load, `VERIFY` runs for `CHAIN_LEN` cycles with `ccff_shift_en`=1 and `ccff_head`=`ccff_tail` (recirculation).
  - A second CRC-8 is computed over the sampled `ccff_tail` bits.
  - At the end of `VERIFY`, `err` is set if the second CRC differs from the load CRC.
  - The chain ends holding its loaded contents. Total latency increases by `CHAIN_LEN` cycles.
- Undefined: no `VERIFY` state, `ccff_tail` is unused, and `err` is tied to 0.

## Test plan
Bench model: a `CHAIN_LEN`-bit shift register clocked when `ccff_shift_en`=1, with `CHAIN_LEN`=20.
- Reset: assert `reset` asynchronously mid-cycle → all outputs 0 immediately; `data_ready`=0 until `start`.
- Load: `start`, then bytes 0xA5, 0x3C, 0xF0 with `data_valid` held → chain receives 1010_0101_0011_1100_1111 in that order. There are exactly 20 shift-enable cycles, and `done` pulses 23 cycles after the first accept.
- Backpressure: drop `data_valid` for 5 cycles before the second byte → `ccff_shift_en`=0 throughout the gap, chain contents are identical to the previous case, and `done` is delayed by exactly 5 cycles.
- Protocol: pulse `start` while `busy`, and drive `data_valid` during `SHIFT` → both are ignored, and the byte count and chain contents are unchanged.
- Readback (macro defined):
  - Unmodified chain → 20 verify cycles, `err`=0, and the chain still holds the loaded pattern.
  - Bench flips bit 7 of the model before `VERIFY` → `err`=1 at `done`, and `err` stays set until the next `start`.
- Reset mid-`SHIFT` (third bit of the second byte) → `busy`=0 and `ccff_shift_en`=0. A new `start` followed by a full reload produces the correct chain and `done`.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
//   Byte-to-serial loader for a configuration (ccff) chain. Bytes arrive over
//   a valid/ready handshake and are serialised MSB-first onto ccff_head until
//   exactly CHAIN_LEN bits have been presented. ccff_shift_en marks the
//   prog_clk edges on which the chain advances and is used upstream to gate
//   the chain clock.
//
//   Optional feature macro: CCFF_READBACK_EN
//     When defined, the load is followed by a CHAIN_LEN-cycle recirculation
//     pass (ccff_head = ccff_tail) that recomputes a CRC-8 over the tail bits
//     and raises the sticky err flag if it differs from the load CRC.
//     When undefined, ccff_tail is ignored and err is always 0.
//
// Ports
//   prog_clk      in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   start         in   begin a load (ignored while busy)
//   data_in[7:0]  in   configuration byte
//   data_valid    in   data_in is valid
//   data_ready    out  a byte is accepted this cycle if data_valid is high
//   ccff_head     out  serial bit to the chain head
//   ccff_shift_en out  chain advances on this edge
//   ccff_tail     in   chain tail (readback only)
//   busy          out  load or verify in progress
//   done          out  one-cycle completion pulse
//   err           out  sticky readback mismatch, cleared by start
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | data_ready high, waiting for a byte
// SHIFT  | presenting byte bits on ccff_head with ccff_shift_en high
// VERIFY | recirculating the chain and recomputing the CRC (readback only)
// FIN    | done pulse, busy low
module ccff_bitstream_loader #(
   parameter int CHAIN_LEN = 72,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic       prog_clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       ccff_head,
   output logic       ccff_shift_en,
   input  logic       ccff_tail,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      SHIFT  = 3'd2,
      VERIFY = 3'd3,
      FIN    = 3'd4
   } state_t;

   state_t           state;
   logic [7:0]       sreg;
   logic [CNT_W-1:0] rem_cnt;   // chain bits not yet presented (verify cycles left in VERIFY)
   logic [2:0]       byte_cnt;  // bits of the current byte still to present after this one
   logic             head_q;

`ifdef CCFF_READBACK_EN
   logic [7:0] crc_load;
   logic [7:0] crc_rb;
   logic       err_q;
`endif

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
      logic fb;
      fb = crc[7] ^ b;
      return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction

   always_ff @(posedge prog_clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         sreg          <= 8'h00;
         rem_cnt       <= '0;
         byte_cnt      <= 3'd0;
         head_q        <= 1'b0;
         data_ready    <= 1'b0;
         ccff_shift_en <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
`ifdef CCFF_READBACK_EN
         crc_load      <= 8'h00;
         crc_rb        <= 8'h00;
         err_q         <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= FETCH;
                  data_ready <= 1'b1;
                  busy       <= 1'b1;
                  rem_cnt    <= CNT_W'(CHAIN_LEN);
`ifdef CCFF_READBACK_EN
                  crc_load   <= 8'h00;
                  err_q      <= 1'b0;
`endif
               end
            end

            FETCH: begin
               // The MSB goes out in the very next cycle, so it is taken
               // straight from data_in and the remainder parked in sreg.
               if (data_valid) begin
                  state         <= SHIFT;
                  data_ready    <= 1'b0;
                  ccff_shift_en <= 1'b1;
                  head_q        <= data_in[7];
                  sreg          <= {data_in[6:0], 1'b0};
                  rem_cnt       <= rem_cnt - CNT_W'(1);
                  byte_cnt      <= 3'd7;
`ifdef CCFF_READBACK_EN
                  crc_load      <= crc8_step(crc_load, data_in[7]);
`endif
               end
            end

            SHIFT: begin
               if (byte_cnt != 3'd0 && rem_cnt != '0) begin
                  head_q   <= sreg[7];
                  sreg     <= {sreg[6:0], 1'b0};
                  rem_cnt  <= rem_cnt - CNT_W'(1);
                  byte_cnt <= byte_cnt - 3'd1;
`ifdef CCFF_READBACK_EN
                  crc_load <= crc8_step(crc_load, sreg[7]);
`endif
               end else if (rem_cnt != '0) begin
                  state         <= FETCH;
                  data_ready    <= 1'b1;
                  ccff_shift_en <= 1'b0;
               end else begin
`ifdef CCFF_READBACK_EN
                  // Shift enable stays high straight into the recirculation pass.
                  state   <= VERIFY;
                  rem_cnt <= CNT_W'(CHAIN_LEN);
                  crc_rb  <= 8'h00;
`else
                  state         <= FIN;
                  ccff_shift_en <= 1'b0;
                  busy          <= 1'b0;
                  done          <= 1'b1;
`endif
               end
            end

`ifdef CCFF_READBACK_EN
            VERIFY: begin
               crc_rb <= crc8_step(crc_rb, ccff_tail);
               if (rem_cnt == CNT_W'(1)) begin
                  state         <= FIN;
                  ccff_shift_en <= 1'b0;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  err_q         <= (crc8_step(crc_rb, ccff_tail) != crc_load);
               end else begin
                  rem_cnt <= rem_cnt - CNT_W'(1);
               end
            end
`endif

            FIN: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CCFF_READBACK_EN
   // Recirculation needs the tail bit on the head in the same cycle, so the
   // head is a bypass mux during VERIFY rather than a registered copy.
   assign ccff_head = (state == VERIFY) ? ccff_tail : head_q;
   assign err       = err_q;
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
   assign ccff_head   = head_q;
   assign err         = 1'b0;
`endif

endmodule
